syscall_controller: RTL and testbench

Sequences MIPS syscalls reaching the execute stage. It holds the pipeline while a syscall runs and turns print_int and put_c into a byte stream on a valid/ready console port. print_int uses serial decimal conversion. Exit raises a sticky halt once all output has drained.

---
 rtl/syscall_controller.sv | 178 +++++++++++++++++
 tb/tb_syscall_controller.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/syscall_controller.sv
// Syscall sequencer for the execute stage: stalls the pipeline while put_c / print_int stream
// bytes to a valid/ready console, and raises a sticky halt on exit.
module syscall_controller #(
  parameter logic [31:0] FUNCT_PRINT_INT = 32'd1,
  parameter logic [31:0] FUNCT_EXIT      = 32'd10,
  parameter logic [31:0] FUNCT_PUT_C     = 32'd11,
  parameter int unsigned INT_NEWLINE     = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        is_syscall,
  input  logic [31:0] syscall_funct,
  input  logic [31:0] syscall_param1,
  output logic        stall,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        halted
);

  typedef enum logic [2:0] {
    StIdle, StPutc, StSign, StDigit, StEmit, StNl, StDone, StHalt
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] param_q, param_d;
  logic [31:0] mag_q, mag_d;
  logic [3:0]  k_q, k_d;
  logic [3:0]  d_q, d_d;
  logic        started_q, started_d;
  logic        out_valid_q, out_valid_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        halted_q, halted_d;
  logic        xfer;

  function automatic logic [31:0] pow10(input logic [3:0] k);
    case (k)
      4'd0:    pow10 = 32'd1;
      4'd1:    pow10 = 32'd10;
      4'd2:    pow10 = 32'd100;
      4'd3:    pow10 = 32'd1000;
      4'd4:    pow10 = 32'd10000;
      4'd5:    pow10 = 32'd100000;
      4'd6:    pow10 = 32'd1000000;
      4'd7:    pow10 = 32'd10000000;
      4'd8:    pow10 = 32'd100000000;
      default: pow10 = 32'd1000000000;
    endcase
  endfunction

  assign xfer = out_valid_q & out_ready;

  always_comb begin
    state_d     = state_q;
    param_d     = param_q;
    mag_d       = mag_q;
    k_d         = k_q;
    d_d         = d_q;
    started_d   = started_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    halted_d    = halted_q;

    case (state_q)
      StIdle: begin
        if (is_syscall) begin
          param_d = syscall_param1;
          if (syscall_funct == FUNCT_PUT_C) begin
            state_d     = StPutc;
            out_valid_d = 1'b1;
            out_data_d  = syscall_param1[7:0];
          end else if (syscall_funct == FUNCT_PRINT_INT) begin
            state_d = StSign;
            // The '-' is registered on entry so SIGN can hand it over directly.
            if (syscall_param1[31]) begin
              out_valid_d = 1'b1;
              out_data_d  = 8'h2D;
            end
          end else if (syscall_funct == FUNCT_EXIT) begin
            state_d  = StHalt;
            halted_d = 1'b1;
          end else begin
            state_d = StDone;
          end
        end
      end
      StPutc: begin
        if (xfer) begin
          out_valid_d = 1'b0;
          state_d     = StDone;
        end
      end
      StSign: begin
        mag_d     = param_q[31] ? (32'd0 - param_q) : param_q;
        k_d       = 4'd9;
        d_d       = 4'd0;
        started_d = 1'b0;
        if (!param_q[31]) begin
          state_d = StDigit;
        end else if (xfer) begin
          out_valid_d = 1'b0;
          state_d     = StDigit;
        end
      end
      StDigit: begin
        if (mag_q >= pow10(k_q)) begin
          mag_d = mag_q - pow10(k_q);
          d_d   = d_q + 4'd1;
        end else if (d_q != 4'd0 || started_q || k_q == 4'd0) begin
          out_valid_d = 1'b1;
          out_data_d  = 8'h30 + {4'd0, d_q};
          started_d   = 1'b1;
          state_d     = StEmit;
        end else begin
          k_d = k_q - 4'd1;
          d_d = 4'd0;
        end
      end
      StEmit: begin
        if (xfer) begin
          out_valid_d = 1'b0;
          if (k_q == 4'd0) begin
            if (INT_NEWLINE != 0) begin
              state_d     = StNl;
              out_valid_d = 1'b1;
              out_data_d  = 8'h0A;
            end else begin
              state_d = StDone;
            end
          end else begin
            k_d     = k_q - 4'd1;
            d_d     = 4'd0;
            state_d = StDigit;
          end
        end
      end
      StNl: begin
        if (xfer) begin
          out_valid_d = 1'b0;
          state_d     = StDone;
        end
      end
      StDone:  state_d = StIdle;
      StHalt:  halted_d = 1'b1;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      param_q     <= '0;
      mag_q       <= '0;
      k_q         <= '0;
      d_q         <= '0;
      started_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      param_q     <= param_d;
      mag_q       <= mag_d;
      k_q         <= k_d;
      d_q         <= d_d;
      started_q   <= started_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      halted_q    <= halted_d;
    end
  end

  assign stall     = (is_syscall & (state_q != StDone)) | (state_q == StHalt);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_syscall_controller.sv
// Scoreboard bench: the driver pushes the expected console text, a monitor pops on each
// transfer and also checks that held bytes stay stable.
module tb_syscall_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        is_syscall;
  logic [31:0] syscall_funct;
  logic [31:0] syscall_param1;
  logic        stall;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        halted;

  syscall_controller dut (
    .clock          (clock),
    .reset          (reset),
    .is_syscall     (is_syscall),
    .syscall_funct  (syscall_funct),
    .syscall_param1 (syscall_param1),
    .stall          (stall),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .halted         (halted)
  );

  always #5 clock = ~clock;

  int         n_checks   = 0;
  int         n_fail     = 0;
  int         ready_mode = 1;  // 0: random, 1: always ready, 2: never ready
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Expected text comes from the simulator's own decimal formatting.
  task automatic push_int(input logic [31:0] p);
    string s;
    s = $sformatf("%0d", $signed(p));
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    exp_q.push_back(8'h0A);
  endtask

  // Monitor: picks out_ready for the coming edge, then scores the byte if it will transfer.
  initial begin
    logic       hold;
    logic [7:0] hold_data;
    logic [7:0] e;
    hold = 1'b0;
    hold_data = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        hold = 1'b0;
        continue;
      end
      case (ready_mode)
        0:       out_ready = 1'($urandom_range(0, 1));
        1:       out_ready = 1'b1;
        default: out_ready = 1'b0;
      endcase
      if (hold) begin
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_data", {24'd0, out_data}, {24'd0, hold_data});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_byte: got %0h, expected no byte", out_data);
        end else begin
          e = exp_q.pop_front();
          check("byte", {24'd0, out_data}, {24'd0, e});
        end
        hold = 1'b0;
      end else begin
        hold = out_valid;
      end
      hold_data = out_data;
    end
  end

  // Presents one syscall and waits for the cycle where the pipeline may advance.
  task automatic issue(input logic [31:0] f, input logic [31:0] p, output int high_cycles);
    is_syscall     = 1'b1;
    syscall_funct  = f;
    syscall_param1 = p;
    high_cycles    = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      if (!stall) break;
      high_cycles++;
    end
    if (stall) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_timeout: stall still 1 after 3000 cycles, expected 0");
    end
    @(posedge clock);
    #1;
    is_syscall = 1'b0;
  endtask

  initial begin
    int          hc;
    int          kind;
    logic [31:0] p;
    logic [31:0] f;
    logic        found;

    reset          = 1'b1;
    is_syscall     = 1'b0;
    syscall_funct  = '0;
    syscall_param1 = '0;
    out_ready      = 1'b0;
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // put_c
    ready_mode = 1;
    exp_q.push_back(8'h41);
    issue(32'd11, 32'h12345641, hc);
    check("putc_drained", exp_q.size(), 32'd0);

    // most negative integer
    push_int(32'h80000000);
    issue(32'd1, 32'h80000000, hc);
    check("minint_drained", exp_q.size(), 32'd0);

    // back-to-back print_int 0 then 907: DONE is one cycle, next syscall stalls again
    push_int(32'd0);
    push_int(32'd907);
    issue(32'd1, 32'd0, hc);
    check("zero_drained", exp_q.size(), 32'd4);
    issue(32'd1, 32'd907, hc);
    check("b2b_restall", {31'd0, hc > 0}, 32'd1);
    check("b2b_drained", exp_q.size(), 32'd0);

    // 42 with a randomly toggling console
    ready_mode = 0;
    push_int(32'd42);
    issue(32'd1, 32'd42, hc);
    check("rand42_drained", exp_q.size(), 32'd0);

    // unknown funct: one stalled cycle, no output
    ready_mode = 1;
    issue(32'd5, 32'h41, hc);
    check("unknown_stall_cycles", hc, 32'd1);

    // randomized mix
    for (int n = 0; n < 30; n++) begin
      ready_mode = int'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 3));
      p = $urandom;
      case (kind)
        0: begin
          exp_q.push_back(p[7:0]);
          issue(32'd11, p, hc);
        end
        1: begin
          push_int(p);
          issue(32'd1, p, hc);
        end
        2: begin
          f = $urandom | 32'h0000_0100;
          issue(f, p, hc);
          check("rand_unknown_stall", hc, 32'd1);
        end
        default: begin
          p = 32'($signed(int'($urandom_range(0, 2000))) - 1000);
          push_int(p);
          issue(32'd1, p, hc);
        end
      endcase
      check("rand_drained", exp_q.size(), 32'd0);
    end

    // reset while '4' of 42 is waiting on the console
    ready_mode     = 2;
    is_syscall     = 1'b1;
    syscall_funct  = 32'd1;
    syscall_param1 = 32'd42;
    found          = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clock);
      if (out_valid && out_data == 8'h34) begin
        found = 1'b1;
        break;
      end
    end
    check("reached_emit4", {31'd0, found}, 32'd1);
    is_syscall = 1'b0;
    reset      = 1'b1;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_halted", {31'd0, halted}, 32'd0);
    check("midrst_stall", {31'd0, stall}, 32'd0);
    exp_q.delete();
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    ready_mode = 1;
    exp_q.push_back(8'h42);
    issue(32'd11, 32'h42, hc);
    check("post_rst_drained", exp_q.size(), 32'd0);

    // exit: sticky halt with stall held
    is_syscall     = 1'b1;
    syscall_funct  = 32'd10;
    syscall_param1 = 32'd0;
    @(negedge clock);
    check("exit_stall_idle", {31'd0, stall}, 32'd1);
    @(negedge clock);
    check("exit_halted", {31'd0, halted}, 32'd1);
    @(posedge clock);
    #1;
    is_syscall = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      check("halt_sticky", {30'd0, halted, stall}, 32'd3);
    end
    check("halt_no_bytes", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
